router_odata_arbiter: RTL and testbench

Round-robin, packet-locked output arbiter for one router output port in the router_wrap slice. It shares the registered ODATA output (the per-bit ff_ODATA flops) among NUM_IN input ports and grants whole packets in wormhole fashion. It also enforces credit-based flow control toward the downstream router, so ODATA only carries a flit when the receiver has buffer space.

---
 rtl/router_odata_arbiter.sv | 115 +++++++++++
 tb/tb_router_odata_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/router_odata_arbiter.sv
// Round-robin, packet-locked arbiter driving one router output port's registered ODATA,
// with credit-based flow control toward the downstream router.
module router_odata_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4,
  localparam int IDW    = $clog2(NUM_IN),
  localparam int CW     = $clog2(CREDITS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_IN-1:0]        i_in_valid,
  input  logic [NUM_IN-1:0]        i_in_head,
  input  logic [NUM_IN-1:0]        i_in_tail,
  input  logic [NUM_IN*DATA_W-1:0] i_in_data,
  output logic [NUM_IN-1:0]        o_in_ready,
  input  logic                     i_credit_in,
  output logic [DATA_W-1:0]        o_odata,
  output logic                     o_ovalid,
  output logic [IDW-1:0]           o_grant_id,
  output logic                     o_busy,
  output logic                     o_credit_err
);

  // state    | meaning
  // S_IDLE   | arbitrating among head flits, round-robin from r_rr_ptr
  // S_LOCKED | o_grant_id owns the output until its tail flit transfers
  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [CW-1:0]   r_credits;

  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_win;
  logic            w_found;
  logic [IDW-1:0]  w_sel;
  logic            w_req;
  logic            w_xfer;
  logic [IDW-1:0]  w_next;
  logic [DATA_W-1:0] w_data;
  logic [NUM_IN-1:0] w_ready;

  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_idx = IDW'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_IN));
      if (!w_found && i_in_valid[w_idx] && i_in_head[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_sel  = (r_state == S_LOCKED) ? o_grant_id : w_win;
    w_req  = (r_state == S_LOCKED) ? i_in_valid[o_grant_id] : w_found;
    // Credits are checked against the registered count only, so in_ready never sees credit_in.
    w_xfer = w_req && (r_credits != '0) && !i_reset;
    w_next = (w_sel == IDW'(NUM_IN - 1)) ? '0 : w_sel + IDW'(1);
    w_data = i_in_data[int'(w_sel)*DATA_W +: DATA_W];
    w_ready        = '0;
    w_ready[w_sel] = w_xfer;
  end

  assign o_in_ready = w_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_credits    <= CW'(CREDITS);
      o_odata      <= '0;
      o_ovalid     <= 1'b0;
      o_grant_id   <= '0;
      o_busy       <= 1'b0;
      o_credit_err <= 1'b0;
    end else begin
      o_ovalid <= w_xfer;
      if (w_xfer) o_odata <= w_data;

      if (w_xfer && !i_credit_in) begin
        r_credits <= r_credits - CW'(1);
      end else if (!w_xfer && i_credit_in) begin
        if (r_credits == CW'(CREDITS)) o_credit_err <= 1'b1;
        else                           r_credits    <= r_credits + CW'(1);
      end

      if (w_xfer) begin
        case (r_state)
          S_IDLE: begin
            o_grant_id <= w_sel;
            if (i_in_tail[w_sel]) begin
              r_rr_ptr <= w_next;
            end else begin
              r_state <= S_LOCKED;
              o_busy  <= 1'b1;
            end
          end
          S_LOCKED: begin
            if (i_in_tail[w_sel]) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_next;
              o_busy   <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_odata_arbiter.sv
// Bench for router_odata_arbiter: hand-derived directed vectors, then random traffic
// checked against a packet-level reference model.
module tb_router_odata_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid, in_head, in_tail, in_ready;
  logic [N*DW-1:0] in_data;
  logic            credit_in;
  logic [DW-1:0]   odata;
  logic            ovalid, busy, credit_err;
  logic [1:0]      grant_id;

  router_odata_arbiter #(.NUM_IN(N), .DATA_W(DW), .CREDITS(CR)) dut (
    .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_in_head(in_head),
    .i_in_tail(in_tail), .i_in_data(in_data), .o_in_ready(in_ready),
    .i_credit_in(credit_in), .o_odata(odata), .o_ovalid(ovalid),
    .o_grant_id(grant_id), .o_busy(busy), .o_credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: packet ownership, round-robin pointer and credit pool as plain ints.
  bit          m_locked;
  int          m_owner, m_ptr, m_cred;
  bit          m_err, m_ov, m_busy;
  logic [31:0] m_od;
  int          m_gid;
  int          m_sel;
  bit          m_xfer;

  function automatic logic [31:0] port_data(input logic [31:0] d, input int p);
    return d + (32'(p) << 28);
  endfunction

  task automatic model_eval(input logic rst, input logic [3:0] v, input logic [3:0] h);
    m_sel  = -1;
    m_xfer = 0;
    if (!rst) begin
      if (m_locked) begin
        if (v[m_owner]) m_sel = m_owner;
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          int p = (m_ptr + k) % N;
          if (v[p] && h[p]) m_sel = p;
        end
      end
      m_xfer = (m_sel >= 0) && (m_cred > 0);
    end
  endtask

  task automatic model_update(input logic rst, input logic [3:0] t, input logic cr,
                              input logic [31:0] d);
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CR; m_err = 0;
      m_ov = 0; m_od = '0; m_gid = 0; m_busy = 0;
    end else begin
      m_ov = m_xfer;
      if (m_xfer) m_od = port_data(d, m_sel);
      if (m_xfer && !cr) m_cred--;
      else if (!m_xfer && cr) begin
        if (m_cred == CR) m_err = 1;
        else m_cred++;
      end
      if (m_xfer) begin
        if (!m_locked) begin
          m_gid = m_sel;
          if (t[m_sel]) m_ptr = (m_sel + 1) % N;
          else begin m_locked = 1; m_owner = m_sel; m_busy = 1; end
        end else if (t[m_sel]) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N; m_busy = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] h,
                       input logic [3:0] t, input logic cr, input logic [31:0] d);
    reset = rst; in_valid = v; in_head = h; in_tail = t; credit_in = cr;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = port_data(d, i);
    model_eval(rst, v, h);
    @(negedge clk);
  endtask

  task automatic model_check(input int cyc);
    logic [3:0] er;
    er = '0;
    if (m_xfer) er[m_sel] = 1'b1;
    chk($sformatf("mdl_ready@%0d", cyc), 64'(in_ready), 64'(er));
    chk($sformatf("mdl_ovalid@%0d", cyc), 64'(ovalid), 64'(m_ov));
    chk($sformatf("mdl_odata@%0d", cyc), 64'(odata), 64'(m_od));
    chk($sformatf("mdl_gid@%0d", cyc), 64'(grant_id), 64'(m_gid));
    chk($sformatf("mdl_busy@%0d", cyc), 64'(busy), 64'(m_busy));
    chk($sformatf("mdl_err@%0d", cyc), 64'(credit_err), 64'(m_err));
  endtask

  task automatic advance(input logic rst, input logic [3:0] t, input logic cr,
                         input logic [31:0] d);
    @(posedge clk);
    model_update(rst, t, cr, d);
    #1;
  endtask

  typedef struct {
    logic rst; logic [3:0] v, h, t; logic cr; logic [31:0] d;
    logic [3:0] rdy; logic ov; logic [31:0] od; logic [1:0] gid; logic busy; logic err;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] h,
                              input logic [3:0] t, input logic cr, input logic [31:0] d,
                              input logic [3:0] rdy, input logic ov, input logic [31:0] od,
                              input logic [1:0] gid, input logic bsy, input logic err);
    vec_t r;
    r.rst = rst; r.v = v; r.h = h; r.t = t; r.cr = cr; r.d = d;
    r.rdy = rdy; r.ov = ov; r.od = od; r.gid = gid; r.busy = bsy; r.err = err;
    return r;
  endfunction

  initial begin
    // reset held with every port offering a single-flit head
    tbl[0]  = mk(1, 4'hF, 4'hF, 4'hF, 0, 32'h11, 4'h0, 0, 32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 4'hF, 4'hF, 4'hF, 0, 32'h11, 4'h0, 0, 32'h0,        0, 0, 0);
    tbl[2]  = mk(1, 4'hF, 4'hF, 4'hF, 0, 32'h11, 4'h0, 0, 32'h0,        0, 0, 0);
    // round-robin fairness, credit returned every cycle after the first transfer
    tbl[3]  = mk(0, 4'hF, 4'hF, 4'hF, 0, 32'h11, 4'h1, 0, 32'h0,        0, 0, 0);
    tbl[4]  = mk(0, 4'hF, 4'hF, 4'hF, 1, 32'h22, 4'h2, 1, 32'h11,       0, 0, 0);
    tbl[5]  = mk(0, 4'hF, 4'hF, 4'hF, 1, 32'h33, 4'h4, 1, 32'h10000022, 1, 0, 0);
    tbl[6]  = mk(0, 4'hF, 4'hF, 4'hF, 1, 32'h44, 4'h8, 1, 32'h20000033, 2, 0, 0);
    tbl[7]  = mk(0, 4'hF, 4'hF, 4'hF, 1, 32'h55, 4'h1, 1, 32'h30000044, 3, 0, 0);
    tbl[8]  = mk(0, 4'h2, 4'h2, 4'h2, 1, 32'h66, 4'h2, 1, 32'h55,       0, 0, 0);
    // port 2 three-flit packet A0,B0,C0 while port 1 waits with a head
    tbl[9]  = mk(0, 4'h6, 4'h6, 4'h2, 1, 32'hA0, 4'h4, 1, 32'h10000066, 1, 0, 0);
    tbl[10] = mk(0, 4'h6, 4'h2, 4'h2, 1, 32'hB0, 4'h4, 1, 32'h200000A0, 2, 1, 0);
    tbl[11] = mk(0, 4'h6, 4'h2, 4'h6, 1, 32'hC0, 4'h4, 1, 32'h200000B0, 2, 1, 0);
    tbl[12] = mk(0, 4'h2, 4'h2, 4'h2, 1, 32'hD0, 4'h2, 1, 32'h200000C0, 2, 0, 0);
    tbl[13] = mk(0, 4'h0, 4'h0, 4'h0, 1, 32'h00, 4'h0, 1, 32'h100000D0, 1, 0, 0);
    // credit exhaustion: six-flit packet from port 0, no returns
    tbl[14] = mk(0, 4'h1, 4'h1, 4'h0, 0, 32'h01, 4'h1, 0, 32'h100000D0, 1, 0, 0);
    tbl[15] = mk(0, 4'h1, 4'h0, 4'h0, 0, 32'h02, 4'h1, 1, 32'h01,       0, 1, 0);
    tbl[16] = mk(0, 4'h1, 4'h0, 4'h0, 0, 32'h03, 4'h1, 1, 32'h02,       0, 1, 0);
    tbl[17] = mk(0, 4'h1, 4'h0, 4'h0, 0, 32'h04, 4'h1, 1, 32'h03,       0, 1, 0);
    tbl[18] = mk(0, 4'h1, 4'h0, 4'h0, 0, 32'h05, 4'h0, 1, 32'h04,       0, 1, 0);
    tbl[19] = mk(0, 4'h1, 4'h0, 4'h0, 1, 32'h05, 4'h0, 0, 32'h04,       0, 1, 0);
    tbl[20] = mk(0, 4'h1, 4'h0, 4'h0, 0, 32'h05, 4'h1, 0, 32'h04,       0, 1, 0);
    tbl[21] = mk(0, 4'h1, 4'h0, 4'h1, 0, 32'h06, 4'h0, 1, 32'h05,       0, 1, 0);
    // credit overflow after reset: sticky until the next reset
    tbl[22] = mk(1, 4'h0, 4'h0, 4'h0, 0, 32'h00, 4'h0, 0, 32'h05,       0, 1, 0);
    tbl[23] = mk(0, 4'h0, 4'h0, 4'h0, 1, 32'h00, 4'h0, 0, 32'h0,        0, 0, 0);
    tbl[24] = mk(0, 4'h0, 4'h0, 4'h0, 0, 32'h00, 4'h0, 0, 32'h0,        0, 0, 1);
    tbl[25] = mk(0, 4'h0, 4'h0, 4'h0, 1, 32'h00, 4'h0, 0, 32'h0,        0, 0, 1);
    // reset in the middle of a port 3 packet
    tbl[26] = mk(0, 4'h8, 4'h8, 4'h0, 0, 32'h10, 4'h8, 0, 32'h0,        0, 0, 1);
    tbl[27] = mk(0, 4'h8, 4'h0, 4'h0, 0, 32'h20, 4'h8, 1, 32'h30000010, 3, 1, 1);
    tbl[28] = mk(1, 4'h8, 4'h0, 4'h0, 0, 32'h30, 4'h0, 1, 32'h30000020, 3, 1, 1);
    tbl[29] = mk(0, 4'h9, 4'h9, 4'h1, 0, 32'h40, 4'h1, 0, 32'h0,        0, 0, 0);
    tbl[30] = mk(0, 4'h0, 4'h0, 4'h0, 0, 32'h00, 4'h0, 1, 32'h40,       0, 0, 0);

    reset = 1'b1; in_valid = '0; in_head = '0; in_tail = '0; in_data = '0; credit_in = 1'b0;
    m_sel = -1; m_xfer = 0;
    @(posedge clk);
    model_update(1'b1, 4'h0, 1'b0, 32'h0);
    #1;

    for (int i = 0; i < 31; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].cr, tbl[i].d);
      chk($sformatf("tbl_ready[%0d]", i), 64'(in_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl_ovalid[%0d]", i), 64'(ovalid), 64'(tbl[i].ov));
      chk($sformatf("tbl_odata[%0d]", i), 64'(odata), 64'(tbl[i].od));
      chk($sformatf("tbl_gid[%0d]", i), 64'(grant_id), 64'(tbl[i].gid));
      chk($sformatf("tbl_busy[%0d]", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl_err[%0d]", i), 64'(credit_err), 64'(tbl[i].err));
      advance(tbl[i].rst, tbl[i].t, tbl[i].cr, tbl[i].d);
    end

    for (int c = 0; c < 3000; c++) begin
      logic rst, cr;
      logic [3:0] v, h, t;
      logic [31:0] d;
      rst = ($urandom_range(0, 199) == 0);
      v   = 4'($urandom);
      h   = 4'($urandom) | 4'($urandom);
      t   = 4'($urandom) & 4'($urandom);
      cr  = ($urandom_range(0, 9) < 4);
      d   = 32'($urandom) & 32'h0FFF_FFFF;
      drive(rst, v, h, t, cr, d);
      model_check(c);
      advance(rst, t, cr, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
